// File: rtl/audio_pkg.sv
// Shared audio constants: frame counter bit taps, frame geometry and load points.
package audio_pkg;

  localparam int DATA_W      = 16;
  localparam int CNT_W       = 9;
  localparam int MCLK_BIT    = 1;
  localparam int SCK_BIT     = 3;
  localparam int LRCK_BIT    = 8;
  localparam int FRAME_LEN   = 512;
  localparam int SCK_LEN     = 16;
  localparam int LOAD_PT_I2S = 15;
  localparam int LOAD_PT_LJ  = 511;

  typedef logic [CNT_W-1:0] cnt_t;

  // The request strobe leads the load by one SCK period, wrapping within the frame.
  function automatic cnt_t req_pt(input int load_pt);
    return cnt_t'((load_pt - SCK_LEN + FRAME_LEN) % FRAME_LEN);
  endfunction

endpackage

// File: rtl/speaker_ctrl_if.sv
// Sample inputs from the note generator and the I2S pin outputs toward the DAC.
interface speaker_ctrl_if;

  logic [audio_pkg::DATA_W-1:0] audio_left;
  logic [audio_pkg::DATA_W-1:0] audio_right;
  logic                         sample_req;
  logic                         audio_mclk;
  logic                         audio_sck;
  logic                         audio_lrck;
  logic                         audio_sdin;

  modport master (
    output audio_left, audio_right,
    input  sample_req, audio_mclk, audio_sck, audio_lrck, audio_sdin
  );

  modport slave (
    input  audio_left, audio_right,
    output sample_req, audio_mclk, audio_sck, audio_lrck, audio_sdin
  );

endinterface

// File: rtl/speaker_ctrl.sv
// I2S serializer for the Pmod I2S2: one 9-bit frame counter yields MCLK/SCK/LRCK.
// SPEAKER_I2S_DELAY_EN selects I2S (one-SCK delay); otherwise left-justified.
module speaker_ctrl
  import audio_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  speaker_ctrl_if.slave  aud
);

`ifdef SPEAKER_I2S_DELAY_EN
  localparam int LOAD_PT = LOAD_PT_I2S;
`else
  localparam int LOAD_PT = LOAD_PT_LJ;
`endif

  localparam cnt_t           LOAD_CNT = cnt_t'(LOAD_PT);
  localparam cnt_t           REQ_CNT  = req_pt(LOAD_PT);
  localparam logic [3:0]     SCK_LAST = 4'(SCK_LEN - 1);
  localparam int             SH_W     = 2 * DATA_W;

  cnt_t            cnt_q, cnt_d;
  logic [SH_W-1:0] shreg_q, shreg_d;
  logic            sample_req_q, sample_req_d;

  always_comb begin
    cnt_d        = cnt_q + cnt_t'(1);
    shreg_d      = shreg_q;
    sample_req_d = (cnt_d == REQ_CNT);
    // Shift one cycle before SCK falls so data is stable across the DAC's rising-edge sample.
    if (cnt_q[3:0] == SCK_LAST) begin
      if (cnt_q == LOAD_CNT) begin
        shreg_d = {aud.audio_left, aud.audio_right};
      end else begin
        shreg_d = {shreg_q[SH_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      shreg_q      <= '0;
      sample_req_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      sample_req_q <= sample_req_d;
    end
  end

  assign aud.audio_mclk = cnt_q[MCLK_BIT];
  assign aud.audio_sck  = cnt_q[SCK_BIT];
  assign aud.audio_lrck = cnt_q[LRCK_BIT];
  assign aud.audio_sdin = shreg_q[SH_W-1];
  assign aud.sample_req = sample_req_q;

endmodule

// File: tb/tb_speaker_ctrl.sv
// Scoreboard bench for speaker_ctrl: frame-level reference model pushes the expected
// bit for every SCK period; a monitor pops and compares on each SCK rising edge.
module tb_speaker_ctrl;

`ifdef SPEAKER_I2S_DELAY_EN
  localparam int LOAD_PT = 15;
  localparam int REQ_PT  = 511;
`else
  localparam int LOAD_PT = 511;
  localparam int REQ_PT  = 495;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  speaker_ctrl_if aud ();

  speaker_ctrl dut (
    .clk (clk),
    .rst (rst),
    .aud (aud)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          m_cnt = 0;
  logic [31:0] m_word = '0;
  bit          exp_q[$];
  bit          rand_in = 1'b0;
  int          req_seen = 0;
  logic        sck_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (model cnt=%0d, t=%0t)", name, act, exp, m_cnt, $time);
    end
  endtask

  // Bit shown on the pin during the SCK period starting at frame position c.
  function automatic bit exp_bit(input int c, input logic [31:0] w);
    int j;
    j = ((c - LOAD_PT - 1) & 511) >> 4;
    return w[31 - j];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (m_cnt == LOAD_PT) begin
        m_word = {aud.audio_left, aud.audio_right};
        $display("frame load at cnt=%0d word=%h t=%0t", m_cnt, m_word, $time);
      end
      m_cnt = (m_cnt + 1) % 512;
      if (m_cnt % 16 == 0) exp_q.push_back(exp_bit(m_cnt, m_word));
    end
    @(negedge clk);
    check("clocks", {29'd0, aud.audio_mclk, aud.audio_sck, aud.audio_lrck},
          {29'd0, 1'((m_cnt >> 1) & 1), 1'((m_cnt >> 3) & 1), 1'((m_cnt >> 8) & 1)});
    check("sample_req", {31'd0, aud.sample_req}, {31'd0, (m_cnt == REQ_PT)});
    if (aud.sample_req) req_seen++;
    if (rand_in) begin
      aud.audio_left  = 16'($urandom);
      aud.audio_right = 16'($urandom);
    end
  endtask

  task automatic release_rst();
    rst = 1'b1;
    exp_q.push_back(exp_bit(0, m_word));
  endtask

  task automatic run_to_cnt(input int target);
    for (int i = 0; i < 600; i++) begin
      if (m_cnt == target) return;
      tick();
    end
    check("run_to_cnt_timeout", 32'(m_cnt), 32'(target));
  endtask

  // Monitor: the DAC samples on SCK rising edges; compare against the queued bit.
  initial begin
    forever begin
      @(negedge clk);
      if (aud.audio_sck && !sck_prev) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          check("sdin", {31'd0, aud.audio_sdin}, {31'd0, exp_q.pop_front()});
        end
      end
      sck_prev = aud.audio_sck;
    end
  end

  initial begin
    aud.audio_left  = 16'h0;
    aud.audio_right = 16'h0;
    repeat (10) tick();
    check("reset_outputs",
          {27'd0, aud.audio_mclk, aud.audio_sck, aud.audio_lrck, aud.audio_sdin, aud.sample_req},
          32'd0);
    release_rst();

    // Steady pattern across two frames.
    aud.audio_left  = 16'hA5C3;
    aud.audio_right = 16'h1234;
    repeat (1024) tick();

    // Input change just after the load point: the in-flight frame keeps F000.
    aud.audio_left = 16'hF000;
    repeat (520) tick();
    run_to_cnt(16);
    aud.audio_left = 16'h1000;
    repeat (600) tick();

    // Strobe count over exactly four frames.
    req_seen = 0;
    repeat (2048) tick();
    check("req_count_4_frames", 32'(req_seen), 32'd4);

    // Randomized samples changing every cycle.
    rand_in = 1'b1;
    repeat (4000) tick();
    rand_in = 1'b0;

    // Mid-frame reset with a 1 on the pin.
    aud.audio_left  = 16'hFFFF;
    aud.audio_right = 16'hFFFF;
    repeat (520) tick();
    run_to_cnt(100);
    check("pre_rst_sdin", {31'd0, aud.audio_sdin}, 32'd1);
    #2;
    rst   = 1'b0;
    exp_q.delete();
    m_cnt  = 0;
    m_word = '0;
    #1;
    check("async_rst_outputs",
          {27'd0, aud.audio_mclk, aud.audio_sck, aud.audio_lrck, aud.audio_sdin, aud.sample_req},
          32'd0);
    repeat (3) tick();
    aud.audio_left  = 16'h8001;
    aud.audio_right = 16'h7FFE;
    release_rst();
    repeat (1100) tick();

    rand_in = 1'b1;
    repeat (1100) tick();

    check("sb_backlog", 32'(exp_q.size() > 1), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/speaker_ctrl.md
# speaker_ctrl

Serializes the 16-bit stereo samples `audio_left`/`audio_right` produced by the note generator onto the Pmod I2S2 DAC pins. A single free-running 9-bit frame counter derives MCLK, SCK and LRCK from the 100 MHz system clock. Each frame, both samples are loaded into a shift register and shifted out MSB-first, with one SCK of I2S delay. The block sits between the note generator and the top-level audio pins; the sample inputs are sampled only at the frame load point.

## Interface
- `DATA_W`, 16, sample width per channel; only 16 is supported (32 SCK per frame)
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  asynchronous, active-low reset
- `audio_left`  in  16  left sample, two's-complement/offset as produced upstream; sampled only at the load cycle
- `audio_right`  in  16  right sample; same rules
- `sample_req`  out  1  one-cycle strobe, 16 clk before each load
- `audio_mclk`  out  1  master clock, clk/4 = 25 MHz
- `audio_sck`  out  1  serial bit clock, clk/16 = 6.25 MHz
- `audio_lrck`  out  1  word select, clk/512 ≈ 195.3 kHz; low = left, high = right
- `audio_sdin`  out  1  serial data to DAC

## Operation
- `cnt[8:0]` increments every clk and wraps 511→0; no hold, no enable.
- Clock outputs are direct register bits, so they are glitch-free:
  - `audio_mclk` = `cnt[1]`
  - `audio_sck` = `cnt[3]`
  - `audio_lrck` = `cnt[8]`
- `shreg[31:0]` is updated only when `cnt[3:0]==15`, one cycle before each SCK falling edge:
  - At `cnt==LOAD_PT`: `shreg <= {audio_left, audio_right}`.
  - Otherwise: `shreg <= {shreg[30:0], 1'b0}`.
- `audio_sdin` = `shreg[31]`. Data changes on SCK falling edges and is stable across the rising edge where the DAC samples.
- `sample_req` = 1 when `cnt == LOAD_PT-16` (mod 512).
- Upstream may change the inputs at any time. Only values present in the `cnt==LOAD_PT` cycle are transmitted. There is no backpressure.

## Timing
- Reset (`rst`=0, asynchronous): `cnt`=0, `shreg`=0, and all outputs are 0 (`audio_mclk`, `audio_sck`, `audio_lrck`, `audio_sdin`, `sample_req`).
- Release: counting starts at the first rising `clk` with `rst`=1. The first valid frame begins after the first load; before that, `audio_sdin`=0.
- `LOAD_PT` = 15 (I2S mode):
  - Left MSB is on `audio_sdin` for `cnt` 16..31.
  - Left bit k (15..0) occupies `cnt` 16·(16−k)..16·(16−k)+15.
  - Right MSB occupies `cnt` 272..287.
  - Right LSB occupies `cnt` 0..15 of the next frame.
- Input-to-pin latency: 1 clk from the load cycle to the MSB on `audio_sdin`.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded and no bits from the old `shreg` are emitted afterwards.
- `sample_req` with `LOAD_PT`=15 fires at `cnt`=511.

## Configuration
- `SPEAKER_I2S_DELAY_EN` defined (default build):
  - `LOAD_PT`=15, standard I2S with a one-SCK delay after each LRCK edge.
  - During `cnt` 0..15, `audio_sdin` carries the previous frame's right LSB.
- Not defined:
  - `LOAD_PT`=511, left-justified format.
  - Left MSB is on `audio_sdin` during `cnt` 0..15; right MSB during 256..271.
  - `sample_req` fires at `cnt`=495.
- Clock outputs are identical in both builds.

## Structure
- Shared package `audio_pkg` holds:
  - `MCLK_BIT`=1, `SCK_BIT`=3, `LRCK_BIT`=8
  - `FRAME_LEN`=512, `SCK_LEN`=16
  - `LOAD_PT_I2S`=15, `LOAD_PT_LJ`=511
- No sub-module. The counter, shift register and strobe are inline, about 120–150 lines.

## Test plan
- Reset/idle: hold `rst`=0 for 10 clk → all outputs 0. Release → `audio_mclk` period 4 clk, `audio_sck` period 16 clk, `audio_lrck` period 512 clk with its first rise at `cnt`=256.
- I2S frame: `audio_left`=16'hA5C3, `audio_right`=16'h1234 steady → bits sampled on SCK rising edges in `cnt` 16..271 read A5C3 MSB-first. Bits in 272..511 plus the next frame's 0..15 read 1234.
- Input change timing: change `audio_left` from 16'hF000 to 16'h1000 at `cnt`=16 → current frame still sends F000. The next frame sends 1000.
- `sample_req`: count strobes over 4 frames → exactly 4, each at `cnt`=511, each 1 clk wide.
- Reset mid-frame: assert `rst` at `cnt`=100 with `audio_sdin`=1 → outputs go 0 asynchronously. After release, the first load occurs at `cnt`=15 with the new inputs.
- Build without `SPEAKER_I2S_DELAY_EN`: `audio_left`=16'h8001 → `audio_sdin`=1 during `cnt` 0..15, 0 during 16..239, 1 during 240..255.
